// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: ROM port, branch redirect, decode-side handshake and status.
// The fetch_queue drives the slave side; the ROM/decode environment is the master.
interface fetch_queue_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMEM_AW = 8,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               fetch_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DATA_W-1:0]  imem_data;
    logic               br_taken;
    logic [DATA_W-1:0]  br_target;
    logic               stall;
    logic               out_valid;
    logic [DATA_W-1:0]  out_instr;
    logic [DATA_W-1:0]  out_next_pc;
    logic [DATA_W-1:0]  pc;
    logic [CNT_W-1:0]   count;

    modport slave (
        input  fetch_en, imem_data, br_taken, br_target, stall,
        output imem_addr, out_valid, out_instr, out_next_pc, pc, count
    );

    modport master (
        output fetch_en, imem_data, br_taken, br_target, stall,
        input  imem_addr, out_valid, out_instr, out_next_pc, pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// PC generation, instruction fetch and a DEPTH-entry prefetch FIFO.
// Each entry holds {instruction, PC+PC_INC}; an empty queue presents a NOP (all zeros).
// Interface parameters must match this module's DATA_W/IMEM_AW/DEPTH.
module fetch_queue #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned IMEM_AW  = 8,
    parameter int unsigned PC_INC   = 4,
    parameter int unsigned RESET_PC = 0
) (
    input logic                clk,
    input logic                reset,
    fetch_queue_if.slave       fq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [DATA_W-1:0] npc_mem_q   [DEPTH];

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic              valid;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] pc_inc;

    assign pc_inc = pc_q + DATA_W'(PC_INC);
    assign valid  = (count_q != '0);
    assign pop    = valid && !fq.stall;
    // A full queue may still accept a word when the head leaves in the same cycle.
    assign push   = fq.fetch_en && !fq.br_taken && ((count_q < CNT_W'(DEPTH)) || pop);

    // Head entry read straight from storage; forced to zero (NOP) when empty.
    always_comb begin
        fq.out_valid   = valid;
        fq.out_instr   = '0;
        fq.out_next_pc = '0;
        if (valid) begin
            fq.out_instr   = instr_mem_q[rd_ptr_q];
            fq.out_next_pc = npc_mem_q[rd_ptr_q];
        end
        fq.imem_addr = pc_q[IMEM_AW-1:0];
        fq.pc        = pc_q;
        fq.count     = count_q;
    end

    // Next-state: flush beats push/pop; otherwise pointers and count follow push/pop.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (fq.br_taken) begin
            pc_d     = fq.br_target;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                pc_d     = pc_inc;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= DATA_W'(RESET_PC);
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage; contents are don't-care until the entry is counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= fq.imem_data;
            npc_mem_q[wr_ptr_q]   <= pc_inc;
        end
    end
endmodule
